sb_cfg_track_switch: RTL and testbench

//  Parametrised successor of the fixed 2-side switch block with per-mux config flops.

---
 rtl/sb_cfg_pkg.sv | 21 ++
 rtl/sb_cfg_mux.sv | 21 ++
 rtl/sb_cfg_track_switch.sv | 139 +++++++++++++
 tb/tb_sb_cfg_track_switch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// Shared types and sizing helpers for the configurable track switch block.
package sb_cfg_pkg;

  // Configuration chain fill state.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } cfg_state_e;

  // Select bits needed by one MUX_IN:1 mux.
  function automatic int sel_w(input int mux_in);
    return $clog2(mux_in);
  endfunction

  // Scan chain length: one select field per output track on both sides.
  function automatic int chain_len(input int chan_w, input int mux_in);
    return 2 * chan_w * sel_w(mux_in);
  endfunction

endpackage

// File: rtl/sb_cfg_mux.sv
// One MUX_IN:1 routing mux. Select values beyond the candidate list drive 0.
module sb_cfg_mux
  import sb_cfg_pkg::*;
#(
  parameter int MUX_IN = 4,
  localparam int SEL_W = sel_w(MUX_IN)
) (
  input  logic [MUX_IN-1:0] cand,
  input  logic [SEL_W-1:0]  sel,
  output logic              mux_out
);

  // Compare-and-pick so out-of-range selects fall through to 0.
  always_comb begin
    mux_out = 1'b0;
    for (int i = 0; i < MUX_IN; i++) begin
      if (sel == SEL_W'(i)) mux_out = cand[i];
    end
  end

endmodule

// File: rtl/sb_cfg_track_switch.sv
// Two-side (top/left) switch block with a double-buffered scan-chain config.
// Bits shift into sr; act is loaded only on cfg_commit, so routing never
// changes while the chain is being reprogrammed.
//
// Handshake: there is no valid/ready pair here. cfg_en is a per-cycle shift
// strobe and cfg_commit is a single-cycle pulse; both are sampled on the rising
// edge of prog_clk with no back-pressure. cfg_valid/cfg_err report the outcome
// of the most recent commit from the following cycle on.
module sb_cfg_track_switch
  import sb_cfg_pkg::*;
#(
  parameter int CHAN_W = 5,
  parameter int N_PIN  = 2,
  parameter int MUX_IN = 4,
  localparam int SEL_W     = sel_w(MUX_IN),
  localparam int CHAIN_LEN = chain_len(CHAN_W, MUX_IN),
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_en,
  input  logic              ccff_head,
  input  logic              cfg_commit,
  input  logic [CHAN_W-1:0] chany_top_in,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [N_PIN-1:0]  top_pin_in,
  input  logic [N_PIN-1:0]  left_pin_in,
  output logic [CHAN_W-1:0] chany_top_out,
  output logic [CHAN_W-1:0] chanx_left_out,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err,
  output cfg_state_e        state_dbg,
  output logic [CNT_W-1:0]  cnt_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] sr;
  logic [CHAIN_LEN-1:0] act;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  cfg_state_e           state;
  cfg_state_e           state_nxt;
  logic                 commit_clean;

  // Scan shift register and committed (active) copy; act takes pre-shift sr.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sr  <= '0;
      act <= '0;
    end else begin
      if (cfg_en)     sr  <= {sr[CHAIN_LEN-2:0], ccff_head};
      if (cfg_commit) act <= sr;
    end
  end

  // Saturating bit counter; a commit restarts it, counting a shift in the same cycle.
  always_comb begin
    cnt_nxt = cnt;
    if (cfg_commit)                    cnt_nxt = cfg_en ? CNT_W'(1) : '0;
    else if (cfg_en && cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) cnt <= '0;
    else         cnt <= cnt_nxt;
  end

  // FSM state register.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state <= EMPTY;
    else         state <= state_nxt;
  end

  // FSM next-state: commit wins, but a simultaneous shift leaves one bit counted.
  always_comb begin
    state_nxt = state;
    if (cfg_commit) begin
      state_nxt = cfg_en ? FILLING : EMPTY;
    end else begin
      case (state)
        EMPTY:   if (cfg_en) state_nxt = (cnt_nxt == CNT_MAX) ? FULL : FILLING;
        FILLING: if (cnt_nxt == CNT_MAX) state_nxt = FULL;
        FULL:    state_nxt = FULL;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // FSM outputs: a commit is clean only when the chain was completely filled.
  always_comb begin
    commit_clean = (state == FULL);
  end

  // Commit status flags; cfg_err is sticky until reset.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (cfg_commit) begin
      cfg_valid <= commit_clean;
      if (!commit_clean) cfg_err <= 1'b1;
    end
  end

  assign ccff_tail = sr[CHAIN_LEN-1];
  assign state_dbg = state;
  assign cnt_dbg   = cnt;

  // Candidate wiring and one mux per output track on each side.
  for (genvar t = 0; t < CHAN_W; t++) begin : g_track
    logic [MUX_IN-1:0] cand_top;
    logic [MUX_IN-1:0] cand_left;

    assign cand_top[0]  = chanx_left_in[t];
    assign cand_left[0] = chany_top_in[t];
    for (genvar c = 1; c < MUX_IN - 1; c++) begin : g_cand
      assign cand_top[c]  = chanx_left_in[(t + c) % CHAN_W];
      assign cand_left[c] = chany_top_in[(t + c) % CHAN_W];
    end
    assign cand_top[MUX_IN-1]  = top_pin_in[t % N_PIN];
    assign cand_left[MUX_IN-1] = left_pin_in[t % N_PIN];

    sb_cfg_mux #(.MUX_IN(MUX_IN)) u_top_mux (
      .cand    (cand_top),
      .sel     (act[t*SEL_W +: SEL_W]),
      .mux_out (chany_top_out[t])
    );

    sb_cfg_mux #(.MUX_IN(MUX_IN)) u_left_mux (
      .cand    (cand_left),
      .sel     (act[(CHAN_W + t)*SEL_W +: SEL_W]),
      .mux_out (chanx_left_out[t])
    );
  end

endmodule

// File: tb/tb_sb_cfg_track_switch.sv
// Directed bench for sb_cfg_track_switch at CHAN_W=4, N_PIN=2, MUX_IN=4.
module tb_sb_cfg_track_switch;
  import sb_cfg_pkg::*;

  localparam int CHAN_W = 4;
  localparam int N_PIN  = 2;
  localparam int MUX_IN = 4;
  localparam int CNT_W  = 5;

  logic              prog_clk;
  logic              pReset;
  logic              cfg_en;
  logic              ccff_head;
  logic              cfg_commit;
  logic [CHAN_W-1:0] chany_top_in;
  logic [CHAN_W-1:0] chanx_left_in;
  logic [N_PIN-1:0]  top_pin_in;
  logic [N_PIN-1:0]  left_pin_in;
  logic [CHAN_W-1:0] chany_top_out;
  logic [CHAN_W-1:0] chanx_left_out;
  logic              ccff_tail;
  logic              cfg_valid;
  logic              cfg_err;
  cfg_state_e        state_dbg;
  logic [CNT_W-1:0]  cnt_dbg;

  int vectors     = 0;
  int miscompares = 0;

  sb_cfg_track_switch #(.CHAN_W(CHAN_W), .N_PIN(N_PIN), .MUX_IN(MUX_IN)) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .cfg_en         (cfg_en),
    .ccff_head      (ccff_head),
    .cfg_commit     (cfg_commit),
    .chany_top_in   (chany_top_in),
    .chanx_left_in  (chanx_left_in),
    .top_pin_in     (top_pin_in),
    .left_pin_in    (left_pin_in),
    .chany_top_out  (chany_top_out),
    .chanx_left_out (chanx_left_out),
    .ccff_tail      (ccff_tail),
    .cfg_valid      (cfg_valid),
    .cfg_err        (cfg_err),
    .state_dbg      (state_dbg),
    .cnt_dbg        (cnt_dbg)
  );

  // Clock and watchdog
  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Shift the low n bits of v, MSB first.
  task automatic shift_bits(input logic [31:0] v, input int n);
    cfg_en = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      ccff_head = v[i];
      tick();
    end
    cfg_en    = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    logic [19:0] v20;
    logic [15:0] w16;
    pReset = 1'b0; cfg_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0;
    chanx_left_in = 4'b1010; chany_top_in = 4'b0110;
    top_pin_in = 2'b01; left_pin_in = 2'b10;

    // 1: reset values, pass-through routing
    #2;
    chk("rst_top_out", chany_top_out, 4'b1010);
    chk("rst_left_out", chanx_left_out, 4'b0110);
    chk("rst_valid", cfg_valid, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_tail", ccff_tail, 1'b0);
    chk("rst_state", state_dbg, EMPTY);
    #10 pReset = 1'b1;
    tick();

    // 2: all selects = 3 -> pins
    shift_bits(32'hFFFF, 16);
    chk("t2_state_full", state_dbg, FULL);
    chk("t2_cnt", cnt_dbg, 5'd16);
    chk("t2_top_before", chany_top_out, 4'b1010);
    commit();
    chk("t2_valid", cfg_valid, 1'b1);
    chk("t2_err", cfg_err, 1'b0);
    chk("t2_top_out", chany_top_out, 4'b0101);
    chk("t2_left_out", chanx_left_out, 4'b1010);
    chk("t2_state", state_dbg, EMPTY);
    chk("t2_cnt0", cnt_dbg, 5'd0);

    // 3: outputs follow old act while shifting sel=1 word
    w16 = 16'h5555;
    cfg_en = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      logic [1:0] p;
      p = 2'(i);
      ccff_head = w16[i];
      top_pin_in = p; left_pin_in = ~p;
      chanx_left_in = 4'(i); chany_top_in = 4'(15 - i);
      #1;
      chk("t3_top_hold", chany_top_out, {p[1], p[0], p[1], p[0]});
      chk("t3_left_hold", chanx_left_out, {~p[1], ~p[0], ~p[1], ~p[0]});
      tick();
    end
    cfg_en = 1'b0; ccff_head = 1'b0;
    chanx_left_in = 4'b1010; chany_top_in = 4'b0110;
    top_pin_in = 2'b10; left_pin_in = 2'b10;
    #1;
    chk("t3_top_pre", chany_top_out, 4'b1010);
    chk("t3_left_pre", chanx_left_out, 4'b1010);
    commit();
    chk("t3_top_post", chany_top_out, 4'b0101);
    chk("t3_left_post", chanx_left_out, 4'b0011);

    // 4: underfilled commit, then clean commit with sticky err
    shift_bits(32'h7F, 7);
    chk("t4_cnt7", cnt_dbg, 5'd7);
    chk("t4_filling", state_dbg, FILLING);
    commit();
    chk("t4_err", cfg_err, 1'b1);
    chk("t4_valid", cfg_valid, 1'b0);
    chk("t4_cnt0", cnt_dbg, 5'd0);
    chk("t4_state", state_dbg, EMPTY);
    chk("t4_top_out", chany_top_out, 4'b1010);
    chk("t4_left_out", chanx_left_out, 4'b1001);
    shift_bits(32'h0000, 16);
    commit();
    chk("t4_valid2", cfg_valid, 1'b1);
    chk("t4_err_sticky", cfg_err, 1'b1);
    chk("t4_top_pass", chany_top_out, 4'b1010);
    chk("t4_left_pass", chanx_left_out, 4'b0110);

    // 5: 20-bit overshift, first bit emerges on tail
    v20 = 20'hA00FF;
    cfg_en = 1'b1;
    for (int i = 19; i >= 0; i--) begin
      ccff_head = v20[i];
      tick();
      if (20 - i == 15) chk("t5_tail15", ccff_tail, 1'b0);
      if (20 - i == 16) chk("t5_tail16", ccff_tail, 1'b1);
      if (20 - i == 17) chk("t5_tail17", ccff_tail, 1'b0);
    end
    cfg_en = 1'b0; ccff_head = 1'b0;
    chk("t5_cnt_sat", cnt_dbg, 5'd16);
    chk("t5_full", state_dbg, FULL);
    commit();
    chk("t5_valid", cfg_valid, 1'b1);
    chk("t5_err", cfg_err, 1'b1);
    chk("t5_top_out", chany_top_out, 4'b1010);
    chk("t5_left_out", chanx_left_out, 4'b0110);

    // 6: async reset mid-shift
    shift_bits(32'h1FF, 9);
    chk("t6_tail_pre", ccff_tail, 1'b1);
    chk("t6_cnt_pre", cnt_dbg, 5'd9);
    #2 pReset = 1'b0;
    #1;
    chk("t6_top_out", chany_top_out, 4'b1010);
    chk("t6_left_out", chanx_left_out, 4'b0110);
    chk("t6_tail", ccff_tail, 1'b0);
    chk("t6_valid", cfg_valid, 1'b0);
    chk("t6_err", cfg_err, 1'b0);
    chk("t6_state", state_dbg, EMPTY);
    chk("t6_cnt", cnt_dbg, 5'd0);
    tick();
    pReset = 1'b1;
    tick();

    // 7: shift and commit in the same cycle while FULL
    top_pin_in = 2'b01; left_pin_in = 2'b10;
    shift_bits(32'h1234, 16);
    chk("t7_full", state_dbg, FULL);
    cfg_en = 1'b1; ccff_head = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0;
    chk("t7_top_out", chany_top_out, 4'b1100);
    chk("t7_left_out", chanx_left_out, 4'b0011);
    chk("t7_cnt1", cnt_dbg, 5'd1);
    chk("t7_state", state_dbg, FILLING);
    chk("t7_valid", cfg_valid, 1'b1);
    chk("t7_err", cfg_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
